// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: control inputs and registered video outputs of video_timing_gen.
// oFrameCount exists only when VTG_FRAME_CNT_EN is defined.
interface video_timing_gen_if #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int COLOR_W = 8
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    logic               ienable;
    logic [1:0]         imode;
    logic [COLOR_W-1:0] ored, ogreen, oblue;
    logic               ohSync, ovSync, oDE, oFrameStart;
    logic [HW-1:0]      ohCount;
    logic [VW-1:0]      ovCount;
`ifdef VTG_FRAME_CNT_EN
    logic [15:0]        oFrameCount;
    modport master (input ienable, imode,
                    output ored, ogreen, oblue, ohSync, ovSync, oDE, oFrameStart, ohCount, ovCount, oFrameCount);
    modport slave  (output ienable, imode,
                    input ored, ogreen, oblue, ohSync, ovSync, oDE, oFrameStart, ohCount, ovCount, oFrameCount);
`else
    modport master (input ienable, imode,
                    output ored, ogreen, oblue, ohSync, ovSync, oDE, oFrameStart, ohCount, ovCount);
    modport slave  (output ienable, imode,
                    input ored, ogreen, oblue, ohSync, ovSync, oDE, oFrameStart, ohCount, ovCount);
`endif
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with test patterns, all outputs registered (latency 1).
// Define VTG_FRAME_CNT_EN for a 16-bit frame counter (oFrameCount) and a scrolling mode 3.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 8
) (
    input  logic               inclk,
    input  logic               ireset,
    video_timing_gen_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = BAR_W > 1 ? $clog2(BAR_W) : 1;

    logic [HW-1:0]      hcnt_q, hcnt_d, hc_q;
    logic [VW-1:0]      vcnt_q, vcnt_d, vc_q;
    logic [BW-1:0]      bpix_q, bpix_d;
    logic [2:0]         bar_q, bar_d;
    logic [1:0]         mode_q, mode_d;
    logic [COLOR_W-1:0] grad, chk, m3, r_d, g_d, b_d, r_q, g_q, b_q;
    logic               h_wrap, v_wrap, origin, active, hs_act, vs_act, de_d, bar_end;
    logic               hs_q, vs_q, de_q, fs_q;
`ifdef VTG_FRAME_CNT_EN
    logic [15:0]        fcnt_q, fcnt_d, fc_q;
`endif

    always_comb begin
        h_wrap  = int'(hcnt_q) == H_TOTAL - 1;
        v_wrap  = int'(vcnt_q) == V_TOTAL - 1;
        origin  = hcnt_q == '0 && vcnt_q == '0;
        active  = int'(hcnt_q) < H_ACTIVE && int'(vcnt_q) < V_ACTIVE;
        hs_act  = int'(hcnt_q) >= H_ACTIVE + H_FP && int'(hcnt_q) < H_ACTIVE + H_FP + H_SYNC;
        vs_act  = int'(vcnt_q) >= V_ACTIVE + V_FP && int'(vcnt_q) < V_ACTIVE + V_FP + V_SYNC;
        de_d    = vif.ienable && active;
        bar_end = int'(bpix_q) == BAR_W - 1;
        hcnt_d  = !vif.ienable ? hcnt_q : h_wrap ? '0 : hcnt_q + 1'b1;
        vcnt_d  = !vif.ienable || !h_wrap ? vcnt_q : v_wrap ? '0 : vcnt_q + 1'b1;
        bpix_d  = !vif.ienable ? bpix_q : h_wrap || bar_end ? '0 : bpix_q + 1'b1;
        bar_d   = !vif.ienable ? bar_q : h_wrap ? '0 : bar_end ? bar_q + 1'b1 : bar_q;
        // The pixel at the frame origin already uses the newly sampled mode.
        mode_d  = vif.ienable && origin ? vif.imode : mode_q;
        grad    = COLOR_W'(hcnt_q);
        chk     = {COLOR_W{(|((hcnt_q >> 5) & HW'(1))) ^ (|((vcnt_q >> 5) & VW'(1)))}};
`ifdef VTG_FRAME_CNT_EN
        fcnt_d  = vif.ienable && h_wrap && v_wrap ? fcnt_q + 1'b1 : fcnt_q;
        m3      = COLOR_W'(16'(hcnt_q) + fcnt_q);
`else
        m3      = {1'b1, {(COLOR_W-1){1'b0}}};
`endif
        // Bar index bits map to white, yellow, cyan, green, magenta, red, blue, black.
        r_d = mode_d == 2'd0 ? {COLOR_W{~bar_q[1]}} : mode_d == 2'd1 ? grad : mode_d == 2'd2 ? chk : m3;
        g_d = mode_d == 2'd0 ? {COLOR_W{~bar_q[2]}} : mode_d == 2'd1 ? grad : mode_d == 2'd2 ? chk : m3;
        b_d = mode_d == 2'd0 ? {COLOR_W{~bar_q[0]}} : mode_d == 2'd1 ? grad : mode_d == 2'd2 ? chk : m3;
    end

    always_ff @(posedge inclk or posedge ireset) begin
        if (ireset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            bpix_q <= '0;
            bar_q  <= '0;
            mode_q <= '0;
            hc_q   <= '0;
            vc_q   <= '0;
            de_q   <= 1'b0;
            fs_q   <= 1'b0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            bpix_q <= bpix_d;
            bar_q  <= bar_d;
            mode_q <= mode_d;
            hc_q   <= hcnt_q;
            vc_q   <= vcnt_q;
            de_q   <= de_d;
            fs_q   <= de_d && origin;
            hs_q   <= vif.ienable && hs_act ? HS_POL : ~HS_POL;
            vs_q   <= vif.ienable && vs_act ? VS_POL : ~VS_POL;
            r_q    <= de_d ? r_d : '0;
            g_q    <= de_d ? g_d : '0;
            b_q    <= de_d ? b_d : '0;
        end
    end

`ifdef VTG_FRAME_CNT_EN
    always_ff @(posedge inclk or posedge ireset) begin
        if (ireset) begin
            fcnt_q <= '0;
            fc_q   <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            fc_q   <= fcnt_q;
        end
    end

    assign vif.oFrameCount = fc_q;
`endif

    assign vif.ohCount     = hc_q;
    assign vif.ovCount     = vc_q;
    assign vif.oDE         = de_q;
    assign vif.oFrameStart = fs_q;
    assign vif.ohSync      = hs_q;
    assign vif.ovSync      = vs_q;
    assign vif.ored        = r_q;
    assign vif.ogreen      = g_q;
    assign vif.oblue       = b_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of video_timing_gen with a 24x8 raster, active-high syncs.
module tb_video_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    video_timing_gen_if #(.H_TOTAL(24), .V_TOTAL(8), .COLOR_W(8)) vif ();

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(8)
    ) dut (
        .inclk(clk),
        .ireset(rst),
        .vif(vif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        while (!(int'(vif.ohCount) == h && int'(vif.ovCount) == v) && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (int'(vif.ohCount) != h || int'(vif.ovCount) != v) begin
            errors++;
            $display("FAIL wait_pos got (%0d,%0d) expected (%0d,%0d)", vif.ohCount, vif.ovCount, h, v);
        end
    endtask

    task automatic test_reset();
        vif.ienable = 1'b1;
        vif.imode = 2'd0;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({vif.oDE, vif.ohSync, vif.ovSync, vif.oFrameStart, vif.ohCount, vif.ovCount} !== 12'h000) begin
            errors++;
            $display("FAIL reset_ctl got %h expected 000",
                     {vif.oDE, vif.ohSync, vif.ovSync, vif.oFrameStart, vif.ohCount, vif.ovCount});
        end
        checks++;
        if ({vif.ored, vif.ogreen, vif.oblue} !== 24'h0) begin
            errors++;
            $display("FAIL reset_color got %h expected 000000", {vif.ored, vif.ogreen, vif.oblue});
        end
`ifdef VTG_FRAME_CNT_EN
        checks++;
        if (vif.oFrameCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_fcount got %0d expected 0", vif.oFrameCount);
        end
`endif
    endtask

    task automatic test_timing();
        logic [11:0] exp;
        rst = 1'b0;
        for (int i = 0; i <= 192; i++) begin
            int h = i % 24;
            int v = (i / 24) % 8;
            tick();
            exp = {h < 16 && v < 4, h >= 18 && h <= 20, v == 5 || v == 6, h == 0 && v == 0, 5'(h), 3'(v)};
            checks++;
            if ({vif.oDE, vif.ohSync, vif.ovSync, vif.oFrameStart, vif.ohCount, vif.ovCount} !== exp) begin
                errors++;
                $display("FAIL timing i=%0d got %h expected %h", i,
                         {vif.oDE, vif.ohSync, vif.ovSync, vif.oFrameStart, vif.ohCount, vif.ovCount}, exp);
            end
        end
    endtask

    task automatic test_bars();
        wait_pos(0, 0);
        for (int h = 0; h <= 16; h++) begin
            logic [23:0] exp;
            exp = h < 16 ? bars[h / 2] : 24'h0;
            checks++;
            if ({vif.ored, vif.ogreen, vif.oblue} !== exp) begin
                errors++;
                $display("FAIL bars h=%0d got %h expected %h", h, {vif.ored, vif.ogreen, vif.oblue}, exp);
            end
            tick();
        end
    endtask

    task automatic test_mode_change();
        wait_pos(0, 2);
        vif.imode = 2'd2;
        tick();
        wait_pos(0, 3);
        checks++;
        if ({vif.ored, vif.ogreen, vif.oblue} !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL mode_hold got %h expected ffffff", {vif.ored, vif.ogreen, vif.oblue});
        end
        wait_pos(0, 0);
        checks++;
        if ({vif.oFrameStart, vif.oDE, vif.ored, vif.ogreen, vif.oblue} !== 26'h3000000) begin
            errors++;
            $display("FAIL mode_switch got %h expected 3000000",
                     {vif.oFrameStart, vif.oDE, vif.ored, vif.ogreen, vif.oblue});
        end
        tick();
        checks++;
        if ({vif.oDE, vif.ored, vif.ogreen, vif.oblue} !== 25'h1000000) begin
            errors++;
            $display("FAIL checker_h1 got %h expected 1000000", {vif.oDE, vif.ored, vif.ogreen, vif.oblue});
        end
    endtask

    task automatic test_gradient();
        vif.imode = 2'd1;
        wait_pos(0, 0);
        for (int h = 0; h < 16; h++) begin
            logic [7:0] c;
            c = 8'(h);
            checks++;
            if ({vif.ored, vif.ogreen, vif.oblue} !== {c, c, c}) begin
                errors++;
                $display("FAIL gradient h=%0d got %h expected %h", h, {vif.ored, vif.ogreen, vif.oblue}, {c, c, c});
            end
            tick();
        end
    endtask

    task automatic test_enable();
        wait_pos(6, 1);
        vif.ienable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({vif.oDE, vif.ohSync, vif.ovSync, vif.oFrameStart, vif.ohCount, vif.ovCount, vif.ored, vif.ogreen, vif.oblue}
                !== {4'b0000, 5'd7, 3'd1, 24'h0}) begin
                errors++;
                $display("FAIL frozen k=%0d got de=%b hs=%b vs=%b fs=%b h=%0d v=%0d rgb=%h expected 0 0 0 0 7 1 000000", k,
                         vif.oDE, vif.ohSync, vif.ovSync, vif.oFrameStart, vif.ohCount, vif.ovCount,
                         {vif.ored, vif.ogreen, vif.oblue});
            end
        end
        vif.ienable = 1'b1;
        tick();
        checks++;
        if ({vif.oDE, vif.ohCount, vif.ored, vif.ogreen, vif.oblue} !== {1'b1, 5'd7, 24'h070707}) begin
            errors++;
            $display("FAIL resume got de=%b h=%0d rgb=%h expected 1 7 070707",
                     vif.oDE, vif.ohCount, {vif.ored, vif.ogreen, vif.oblue});
        end
        tick();
        checks++;
        if (vif.ohCount !== 5'd8) begin
            errors++;
            $display("FAIL resume_next got %0d expected 8", vif.ohCount);
        end
        wait_pos(18, 5);
        vif.ienable = 1'b0;
        tick();
        checks++;
        if ({vif.ohSync, vif.ovSync, vif.ohCount} !== {2'b00, 5'd19}) begin
            errors++;
            $display("FAIL sync_frozen got hs=%b vs=%b h=%0d expected 0 0 19", vif.ohSync, vif.ovSync, vif.ohCount);
        end
        vif.ienable = 1'b1;
        tick();
        checks++;
        if ({vif.ohSync, vif.ovSync, vif.ohCount} !== {2'b11, 5'd19}) begin
            errors++;
            $display("FAIL sync_resume got hs=%b vs=%b h=%0d expected 1 1 19", vif.ohSync, vif.ovSync, vif.ohCount);
        end
    endtask

    task automatic test_reset_mid();
        wait_pos(4, 3);
        vif.imode = 2'd3;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({vif.oDE, vif.ohSync, vif.ovSync, vif.oFrameStart, vif.ohCount, vif.ovCount, vif.ored, vif.ogreen, vif.oblue}
            !== 36'h0) begin
            errors++;
            $display("FAIL async_reset got de=%b h=%0d v=%0d rgb=%h expected 0 0 0 000000",
                     vif.oDE, vif.ohCount, vif.ovCount, {vif.ored, vif.ogreen, vif.oblue});
        end
        tick();
        checks++;
        if ({vif.oDE, vif.ohCount, vif.ovCount} !== 9'h0) begin
            errors++;
            $display("FAIL reset_hold got de=%b h=%0d v=%0d expected 0 0 0", vif.oDE, vif.ohCount, vif.ovCount);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({vif.oFrameStart, vif.oDE, vif.ohCount, vif.ovCount} !== {2'b11, 8'h0}) begin
            errors++;
            $display("FAIL reset_release got fs=%b de=%b h=%0d v=%0d expected 1 1 0 0",
                     vif.oFrameStart, vif.oDE, vif.ohCount, vif.ovCount);
        end
    endtask

    task automatic test_mode3();
        for (int f = 0; f < 3; f++) begin
            wait_pos(0, 0);
            for (int h = 0; h < 2; h++) begin
                logic [7:0] c;
`ifdef VTG_FRAME_CNT_EN
                c = 8'(h + f);
                if (h == 0) begin
                    checks++;
                    if (vif.oFrameCount !== 16'(f)) begin
                        errors++;
                        $display("FAIL frame_count got %0d expected %0d", vif.oFrameCount, f);
                    end
                end
`else
                c = 8'h80;
`endif
                checks++;
                if ({vif.ored, vif.ogreen, vif.oblue} !== {c, c, c}) begin
                    errors++;
                    $display("FAIL mode3 f=%0d h=%0d got %h expected %h", f, h,
                             {vif.ored, vif.ogreen, vif.oblue}, {c, c, c});
                end
                tick();
            end
        end
    endtask

    initial begin
        vif.ienable = 1'b1;
        vif.imode = 2'd0;
        test_reset();
        test_timing();
        test_bars();
        test_mode_change();
        test_gradient();
        test_enable();
        test_reset_mid();
        test_mode3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
